// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard/forwarding controller: select encoding,
// register-address width and the shadow-pipeline stage record.
package hazard_forward_unit_pkg;

    localparam int REG_AW = 5;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] FWD_RF    = 2'b00;
    localparam logic [SEL_W-1:0] FWD_EXMEM = 2'b01;
    localparam logic [SEL_W-1:0] FWD_MEMWB = 2'b10;
    localparam logic [SEL_W-1:0] FWD_ZERO  = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regWrite;
        logic              memRead;
    } stage_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_sel_compare.sv
// Priority compare of one decode source register against the EX and MEM
// producers; the nearer producer wins and register 0 is never forwarded.
module fwd_sel_compare
    import hazard_forward_unit_pkg::*;
(
    input  logic [REG_AW-1:0] Src,
    input  logic              SrcUsed,
    input  logic              ExValid,
    input  logic              ExRegWrite,
    input  logic [REG_AW-1:0] ExRd,
    input  logic              MemValid,
    input  logic              MemRegWrite,
    input  logic [REG_AW-1:0] MemRd,
    output logic [SEL_W-1:0]  Sel
);

    always_comb begin
        Sel = FWD_RF;
        if (SrcUsed && (Src != '0)) begin
            if (ExValid && ExRegWrite && (ExRd == Src)) begin
                Sel = FWD_EXMEM;
            end else if (MemValid && MemRegWrite && (MemRd == Src)) begin
                Sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall / bubble generation and registered operand-forwarding selects.
// Define FWD_STALL_COUNT_EN to add the 32-bit StallCount port and counter.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              IdValid,
    input  logic [REG_AW-1:0] IdRs,
    input  logic [REG_AW-1:0] IdRt,
    input  logic              IdUseRs,
    input  logic              IdUseRt,
    input  logic [REG_AW-1:0] IdRd,
    input  logic              IdRegWrite,
    input  logic              IdMemRead,
    input  logic              Flush,
    output logic [SEL_W-1:0]  FwdASel,
    output logic [SEL_W-1:0]  FwdBSel,
    output logic              Stall,
    output logic              Bubble
`ifdef FWD_STALL_COUNT_EN
    ,
    output logic [31:0]       StallCount
`endif
);

    stage_t exStage;
    stage_t memStage;
    stage_t wbStage;

    logic [REG_AW-1:0] srcReg  [2];
    logic              srcUse  [2];
    logic [SEL_W-1:0]  selNext [2];
    logic              loadUse;

    assign srcReg[0] = IdRs;
    assign srcReg[1] = IdRt;
    assign srcUse[0] = IdUseRs;
    assign srcUse[1] = IdUseRt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
            fwd_sel_compare u_cmp (
                .Src         (srcReg[gi]),
                .SrcUsed     (srcUse[gi]),
                .ExValid     (exStage.valid),
                .ExRegWrite  (exStage.regWrite),
                .ExRd        (exStage.rd),
                .MemValid    (memStage.valid),
                .MemRegWrite (memStage.regWrite),
                .MemRd       (memStage.rd),
                .Sel         (selNext[gi])
            );
        end
    endgenerate

    // A load still in EX cannot be forwarded yet; hold the consumer one cycle.
    assign loadUse = IdValid && exStage.valid && exStage.memRead && exStage.regWrite
                  && (exStage.rd != '0)
                  && ((IdUseRs && (IdRs == exStage.rd)) || (IdUseRt && (IdRt == exStage.rd)));

    assign Stall  = loadUse && !Flush;
    assign Bubble = loadUse || Flush;

    // The WB record and the MEM load flag are tracked for completeness only.
    logic unusedBits;
    assign unusedBits = ^{wbStage, memStage.memRead};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            exStage    <= '0;
            memStage   <= '0;
            wbStage    <= '0;
            FwdASel    <= FWD_RF;
            FwdBSel    <= FWD_RF;
`ifdef FWD_STALL_COUNT_EN
            StallCount <= '0;
`endif
        end else begin
            wbStage  <= memStage;
            memStage <= exStage;
            if (Bubble) begin
                exStage <= '0;
                FwdASel <= FWD_RF;
                FwdBSel <= FWD_RF;
            end else begin
                exStage.valid    <= IdValid;
                exStage.rd       <= IdRd;
                exStage.regWrite <= IdRegWrite;
                exStage.memRead  <= IdMemRead;
                FwdASel          <= selNext[0];
                FwdBSel          <= selNext[1];
            end
`ifdef FWD_STALL_COUNT_EN
            if (Stall) begin
                StallCount <= StallCount + 32'd1;
            end
`endif
        end
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard and operand-forwarding controller for the 5-stage datapath. Tracks destination register, write-enable and load flag of the instructions in EX, MEM and WB in its own shadow pipeline. Produces the registered 2-bit select for each ALU operand's 32-bit 3-to-1 forwarding mux, and the load-use stall / bubble controls for the front end. Sits between decode and the EX-stage operand muxes, which it drives.

## Interface
- REG_AW, 5, register-address width
- SEL_W, 2, forwarding-select width (fixed encoding below)
- Clk  input  1  system clock, rising edge
- Rst_n  input  1  asynchronous, active-low reset
- IdValid  input  1  decode-stage instruction valid
- IdRs, IdRt  input  REG_AW  decode source registers
- IdUseRs, IdUseRt  input  1  source actually read
- IdRd  input  REG_AW  decode destination register
- IdRegWrite  input  1  instruction writes register file
- IdMemRead  input  1  instruction is a load
- Flush  input  1  branch/jump taken; kill the instruction in ID
- FwdASel, FwdBSel  output  SEL_W  registered operand-mux selects for the instruction in EX
- Stall  output  1  hold PC and IF/ID this cycle (combinational)
- Bubble  output  1  ID/EX loads a NOP this cycle (combinational)
- StallCount  output  32  load-use stall counter (only with FWD_STALL_COUNT_EN)

## Operation
- Select encoding: 00 register-file operand; 01 EX/MEM ALU result; 10 MEM/WB write-back data; 11 constant zero.
- Shadow stages EX, MEM, WB each hold {valid, rd, regwrite, memread}. They advance every cycle. No global freeze.
- Bubble = Stall | Flush. On Bubble the EX stage loads valid=0 and both selects load 00. Otherwise EX loads the ID fields.
- Load-use: Stall = IdValid & EX.valid & EX.memread & EX.regwrite & EX.rd!=0 & ((IdUseRs & IdRs==EX.rd) | (IdUseRt & IdRt==EX.rd)).
- Flush overrides Stall. When Flush=1, Stall=0 and Bubble=1.
- Select computation for each source s, evaluated at the ID→EX transfer:
  - 01 if EX.valid & EX.regwrite & EX.rd==s & s!=0.
  - Otherwise 10 if MEM.valid & MEM.regwrite & MEM.rd==s & s!=0.
  - Otherwise 00.
  - Unused source → 00.
  - The nearer producer always wins.
- The 01 path never selects a load. The stall guarantees that a load consumer sees the load in WB, i.e. select 10.
- Register 0 is never forwarded and never stalls.
- Sel 11 is never produced in base build.

## Timing
- Reset (Rst_n low, asynchronous) clears every stage valid bit and rd. FwdASel=FwdBSel=00, Stall=0, Bubble=0, StallCount=0.
- Reset released mid-stream: all in-flight records are lost. The first valid ID instruction gets 00 selects.
- Select latency: computed in the ID cycle, visible on FwdASel/FwdBSel the next cycle. Stable for the entire EX cycle.
- Stall and Bubble are combinational in the same cycle as the hazard.
- A load-use stall lasts exactly one cycle. On the next cycle the load is in MEM, EX holds the bubble, and Stall drops.
- Same rd in both EX and MEM: 01.
- Flush and Stall in the same cycle: one bubble only, no stall, StallCount unchanged.

## Configuration
- FWD_STALL_COUNT_EN defined: StallCount port exists.
  - It increments by 1 on every cycle with Stall=1 (post Flush override).
  - It wraps from 0xFFFFFFFF to 0 and resets to 0.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - select constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_ZERO=2'b11;
  - the REG_AW default;
  - the stage-record typedef {valid, rd, regwrite, memread}.
- One sub-module, fwd_sel_compare: combinational priority compare of one source against the EX and MEM records. Returns a 2-bit select. Instantiated twice, for Rs and Rt.

## Test plan
- Reset: assert Rst_n=0 mid-run with EX holding a valid load of rd=8 -> all outputs 0 immediately. After release, a consumer of r8 gets FwdASel=00 and no stall.
- EX/MEM forward: add r3 then add r5,r3,r3 back-to-back -> one cycle later FwdASel=FwdBSel=01, Stall=0.
- MEM/WB forward and priority: add r3; nop; sub r6,r3,r4 -> FwdASel=10, FwdBSel=00. Repeat with add r3; add r3; sub r6,r3 -> FwdASel=01.
- Load-use: lw r2; add r7,r2,r1 -> Stall=1 and Bubble=1 for exactly one cycle, then FwdASel=10. StallCount goes 0→1 when the macro is defined.
- Register 0: add r0; add r1,r0,r0 -> selects 00. lw r0 followed by a use of r0 -> no stall.
- Flush with stall: lw r2 in EX, consumer of r2 in ID, Flush=1 -> Stall=0, Bubble=1, StallCount unchanged.
